// File: rtl/bkm_seq_pkg.sv
// rtl/bkm_seq_pkg.sv - shared state encoding and limits for the BKM LUT sequencer
package bkm_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int LUT_LAT_MAX = 7;
  // Wide enough to hold LUT_LAT_MAX-1.
  localparam int WAIT_W = 3;

endpackage

// File: rtl/bkm_step_reg.sv
// rtl/bkm_step_reg.sv - holding register for one presented BKM step (X, Y, index, last)
module bkm_step_reg #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          srst,
  input  logic          i_load,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] r_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_q <= '0;
    end else if (srst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/bkm_lut_sequencer.sv
// rtl/bkm_lut_sequencer.sv - walks BKM LUT indices 0..n_iter-1 and hands each CSD step to the datapath
module bkm_lut_sequencer
  import bkm_seq_pkg::*;
#(
  parameter int W       = 64,
  parameter int NW      = 6,
  parameter int LUT_LAT = 1
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            srst,
  input  logic            enable,
  input  logic            start,
  input  logic [NW-1:0]   n_iter,
  output logic            busy,
  output logic            lut_rd,
  output logic [NW-1:0]   lut_addr,
  input  logic [2*W-1:0]  lut_X_n_csd,
  input  logic [2*W-1:0]  lut_Y_n_csd,
  output logic            step_valid,
  input  logic            step_ready,
  output logic [NW-1:0]   step_n,
  output logic            step_last,
  output logic [2*W-1:0]  step_X_csd,
  output logic [2*W-1:0]  step_Y_csd,
  output logic            done
);

  localparam int SW = 2 * (2 * W) + NW + 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(LUT_LAT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [NW-1:0]       r_n;
  logic [NW-1:0]       r_n_iter;
  logic [WAIT_W-1:0]   r_wait;
  logic                w_load;
  logic                w_accept;
  logic                w_hs;
  logic [SW-1:0]       w_step_d;
  logic [SW-1:0]       w_step_q;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_hs     = (r_state == ST_PRESENT) && step_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
    end else if (srst) begin
      r_state <= ST_IDLE;
    end else if (enable) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (n_iter == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wait == '0) begin
          w_load = 1'b1;
          w_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (step_ready) begin
          w_next = step_last ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // n stops at n_iter-1, so the increment cannot wrap even for n_iter = 2^NW-1.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_n      <= '0;
      r_n_iter <= '0;
      r_wait   <= '0;
    end else if (srst) begin
      r_n      <= '0;
      r_n_iter <= '0;
      r_wait   <= '0;
    end else if (enable) begin
      if (w_accept && (n_iter != '0)) begin
        r_n_iter <= n_iter;
        r_n      <= '0;
      end
      if (r_state == ST_FETCH) begin
        r_wait <= WAIT_INIT;
      end else if ((r_state == ST_WAIT) && (r_wait != '0)) begin
        r_wait <= r_wait - WAIT_W'(1);
      end
      if (w_hs && !step_last) begin
        r_n <= r_n + NW'(1);
      end
    end
  end

  assign w_step_d = {lut_X_n_csd, lut_Y_n_csd, r_n, (r_n == (r_n_iter - NW'(1)))};

  bkm_step_reg #(
    .DW(SW)
  ) u_step_reg (
    .clk    (clk),
    .arst_n (arst_n),
    .srst   (srst),
    .i_load (w_load && enable),
    .i_d    (w_step_d),
    .o_q    (w_step_q)
  );

  assign {step_X_csd, step_Y_csd, step_n, step_last} = w_step_q;

  assign busy       = (r_state == ST_FETCH) || (r_state == ST_WAIT) || (r_state == ST_PRESENT);
  assign lut_rd     = (r_state == ST_FETCH) && enable;
  assign lut_addr   = r_n;
  assign step_valid = (r_state == ST_PRESENT);
  assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_bkm_lut_sequencer.sv
// tb/tb_bkm_lut_sequencer.sv - scoreboard bench for bkm_lut_sequencer at LUT latencies 1, 2 and 3
module tb_bkm_lut_sequencer;

  localparam int W  = 64;
  localparam int NW = 6;
  localparam int XW = 2 * W;
  localparam int NI = 3;
  localparam int K_RD   = 0;
  localparam int K_STEP = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int kind;
    int inst;
    int n;
    bit last;
    int gap;
  } ev_t;

  typedef struct {
    string         name;
    logic [XW-1:0] act;
    logic [XW-1:0] exp_v;
  } chk_t;

  logic clk = 1'b0;
  logic arst_n, srst, enable, step_ready;
  logic [NW-1:0] n_iter;
  logic [NI-1:0] start_a, busy_a, lut_rd_a, sv_a, sl_a, done_a;
  logic [NI-1:0][NW-1:0] addr_a, sn_a;
  logic [NI-1:0][XW-1:0] sx_a, sy_a;

  ev_t  ev_q[$];
  chk_t chk_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_cyc [NI];
  logic [NI-1:0] prev_stall = '0;
  logic [NI-1:0][XW-1:0] prev_x;
  logic [NI-1:0][NW-1:0] prev_n;

  initial forever #5 clk = ~clk;

  // Instance k runs with LUT_LAT = k+1; its LUT returns X=n, Y=~n only inside the valid window.
  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int LAT = k + 1;
    logic [NW-1:0] pa [LAT];
    logic          pv [LAT];
    logic [XW-1:0] lx, ly;

    always @(posedge clk) begin
      if (!arst_n) begin
        for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
      end else if (enable) begin
        pa[0] <= addr_a[k];
        pv[0] <= lut_rd_a[k];
        for (int i = 1; i < LAT; i++) begin
          pa[i] <= pa[i-1];
          pv[i] <= pv[i-1];
        end
      end
    end

    assign lx = pv[LAT-1] ? XW'(pa[LAT-1])  : {(XW/16){16'hBAD0}};
    assign ly = pv[LAT-1] ? ~XW'(pa[LAT-1]) : {(XW/16){16'h0DEF}};

    bkm_lut_sequencer #(.W(W), .NW(NW), .LUT_LAT(LAT)) u_dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .srst        (srst),
      .enable      (enable),
      .start       (start_a[k]),
      .n_iter      (n_iter),
      .busy        (busy_a[k]),
      .lut_rd      (lut_rd_a[k]),
      .lut_addr    (addr_a[k]),
      .lut_X_n_csd (lx),
      .lut_Y_n_csd (ly),
      .step_valid  (sv_a[k]),
      .step_ready  (step_ready),
      .step_n      (sn_a[k]),
      .step_last   (sl_a[k]),
      .step_X_csd  (sx_a[k]),
      .step_Y_csd  (sy_a[k]),
      .done        (done_a[k])
    );
  end

  task automatic chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic got(input int kind, input int k, input int n, input bit last,
                     input logic [XW-1:0] x, input logic [XW-1:0] y);
    ev_t e;
    if (ev_q.size() == 0) begin
      chk($sformatf("unexpected_event_kind%0d_inst%0d", kind, k), XW'(1), XW'(0));
      return;
    end
    e = ev_q.pop_front();
    chk("event_kind", XW'(kind), XW'(e.kind));
    chk("event_inst", XW'(k), XW'(e.inst));
    if (kind != K_DONE) chk((kind == K_RD) ? "lut_addr" : "step_n", XW'(n), XW'(e.n));
    if (kind == K_STEP) begin
      chk("step_last", XW'(last), XW'(e.last));
      chk("step_X_csd", x, XW'(e.n));
      chk("step_Y_csd", y, ~XW'(e.n));
    end
    if (e.gap != 0) chk("event_gap", XW'(cyc - last_cyc[k]), XW'(e.gap));
    last_cyc[k] = cyc;
  endtask

  initial begin
    chk_t c;
    forever begin
      @(negedge clk);
      cyc++;
      while (chk_q.size() != 0) begin
        c = chk_q.pop_front();
        chk(c.name, c.act, c.exp_v);
      end
      for (int k = 0; k < NI; k++) begin
        if (start_a[k] && !busy_a[k] && enable && arst_n && !srst) last_cyc[k] = cyc;
        if (lut_rd_a[k]) got(K_RD, k, int'(addr_a[k]), 1'b0, '0, '0);
        if (sv_a[k] && step_ready && enable) got(K_STEP, k, int'(sn_a[k]), sl_a[k], sx_a[k], sy_a[k]);
        if (done_a[k]) got(K_DONE, k, 0, 1'b0, '0, '0);
        if (prev_stall[k] && arst_n && !srst) begin
          chk("stall_valid", XW'(sv_a[k]), XW'(1));
          chk("stall_X", sx_a[k], prev_x[k]);
          chk("stall_n", XW'(sn_a[k]), XW'(prev_n[k]));
        end
        prev_stall[k] = sv_a[k] && !(step_ready && enable) && arst_n && !srst;
        prev_x[k] = sx_a[k];
        prev_n[k] = sn_a[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input int inst, input int n, input bit last, input int gap);
    ev_t e;
    e.kind = kind; e.inst = inst; e.n = n; e.last = last; e.gap = gap;
    ev_q.push_back(e);
  endtask

  task automatic push_chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp_v);
    chk_t c;
    c.name = name; c.act = act; c.exp_v = exp_v;
    chk_q.push_back(c);
  endtask

  task automatic push_seq(input int k, input int ni, input int lat);
    for (int i = 0; i < ni; i++) begin
      push_ev(K_RD, k, i, 1'b0, 1);
      push_ev(K_STEP, k, i, (i == ni - 1), lat + 1);
    end
    push_ev(K_DONE, k, 0, 1'b0, 1);
  endtask

  // n_iter is scrambled after the pulse so any late sampling shows up as a wrong step_last.
  task automatic pulse_start(input int k, input int ni);
    start_a[k] = 1'b1;
    n_iter = NW'(ni);
    tick();
    start_a = '0;
    n_iter = 6'h2A;
  endtask

  task automatic drain(input string tag, input int budget);
    int t = 0;
    while (ev_q.size() != 0 && t < budget) begin
      tick();
      t++;
    end
    push_chk({tag, "_pending_events"}, XW'(ev_q.size()), '0);
    ev_q.delete();
    repeat (2) tick();
  endtask

  task automatic wait_rd(input int k, input int a, input string tag);
    int t = 0;
    while (!(lut_rd_a[k] && (addr_a[k] == NW'(a))) && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) push_chk({tag, "_rd_timeout"}, XW'(1), '0);
  endtask

  task automatic wait_valid(input int k, input string tag);
    int t = 0;
    while (!sv_a[k] && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) push_chk({tag, "_valid_timeout"}, XW'(1), '0);
  endtask

  initial begin
    arst_n = 1'b0; srst = 1'b0; enable = 1'b1; step_ready = 1'b1;
    n_iter = '0; start_a = '0;
    repeat (3) @(posedge clk);
    #1;
    push_chk("rst_busy", XW'(busy_a), '0);
    push_chk("rst_lut_rd", XW'(lut_rd_a), '0);
    push_chk("rst_valid", XW'(sv_a), '0);
    push_chk("rst_done", XW'(done_a), '0);
    push_chk("rst_addr_n", XW'({addr_a, sn_a}), '0);
    push_chk("rst_X", sx_a[0], '0);
    push_chk("rst_Y", sy_a[2], '0);
    arst_n = 1'b1;
    tick();

    // LUT_LAT=1, n_iter=4, ready high: rd every 3 cycles, last only on n=3
    push_seq(0, 4, 1);
    pulse_start(0, 4);
    drain("t1", 60);
    push_chk("t1_busy_after", XW'(busy_a[0]), '0);

    // LUT_LAT=3, n_iter=3, 5-cycle stall on step 1
    push_ev(K_RD, 2, 0, 1'b0, 1);
    push_ev(K_STEP, 2, 0, 1'b0, 4);
    push_ev(K_RD, 2, 1, 1'b0, 1);
    push_ev(K_STEP, 2, 1, 1'b0, 9);
    push_ev(K_RD, 2, 2, 1'b0, 1);
    push_ev(K_STEP, 2, 2, 1'b1, 4);
    push_ev(K_DONE, 2, 0, 1'b0, 1);
    pulse_start(2, 3);
    wait_rd(2, 1, "t2");
    step_ready = 1'b0;
    wait_valid(2, "t2");
    repeat (5) tick();
    step_ready = 1'b1;
    drain("t2", 60);

    // n_iter=0: done only
    push_ev(K_DONE, 0, 0, 1'b0, 1);
    pulse_start(0, 0);
    drain("t3", 10);

    // start ignored while busy
    push_seq(1, 2, 2);
    pulse_start(1, 2);
    repeat (2) tick();
    pulse_start(1, 9);
    drain("t4", 40);
    repeat (4) tick();

    // enable low for 4 cycles in WAIT, LUT_LAT=2
    push_ev(K_RD, 1, 0, 1'b0, 1);
    push_ev(K_STEP, 1, 0, 1'b0, 7);
    push_ev(K_RD, 1, 1, 1'b0, 1);
    push_ev(K_STEP, 1, 1, 1'b1, 3);
    push_ev(K_DONE, 1, 0, 1'b0, 1);
    pulse_start(1, 2);
    tick();
    enable = 1'b0;
    repeat (2) tick();
    push_chk("t5_frozen_busy", XW'(busy_a[1]), XW'(1));
    push_chk("t5_frozen_valid", XW'(sv_a[1]), '0);
    repeat (2) tick();
    enable = 1'b1;
    drain("t5", 40);

    // synchronous reset right at the first fetch
    push_ev(K_RD, 2, 0, 1'b0, 1);
    pulse_start(2, 3);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    push_chk("t6_busy", XW'(busy_a[2]), '0);
    repeat (8) tick();
    drain("t6", 5);

    // async reset during PRESENT of step 1, then restart from n=0
    push_ev(K_RD, 0, 0, 1'b0, 1);
    push_ev(K_STEP, 0, 0, 1'b0, 2);
    push_ev(K_RD, 0, 1, 1'b0, 1);
    pulse_start(0, 4);
    wait_rd(0, 1, "t7");
    step_ready = 1'b0;
    wait_valid(0, "t7");
    #2;
    arst_n = 1'b0;
    #1;
    push_chk("t7_valid", XW'(sv_a[0]), '0);
    push_chk("t7_busy", XW'(busy_a[0]), '0);
    push_chk("t7_step_n", XW'(sn_a[0]), '0);
    push_chk("t7_step_X", sx_a[0], '0);
    push_chk("t7_step_Y", sy_a[0], '0);
    push_chk("t7_addr", XW'(addr_a[0]), '0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    step_ready = 1'b1;
    push_chk("t7_pending_events", XW'(ev_q.size()), '0);
    ev_q.delete();
    repeat (6) tick();
    push_seq(0, 2, 1);
    pulse_start(0, 2);
    drain("t7b", 30);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
